// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU for the 16-bit MIPS-style pipeline. Decodes ALUOp/funct
//   into a 3-bit ALU control code, computes the result, and registers result,
//   zero flag, control code and valid. Latency is one clock. There is no
//   stall path, so a new operation is accepted every cycle.
//
//   Optional feature: define ALU_NOR_EN to enable NOR (funct 100111 -> ctl 100).
//
// Ports
//   clock      i  system clock, rising edge
//   reset      i  synchronous active-high reset
//   in_valid   i  operands/op fields qualify this cycle
//   alu_op     i  [1:0] ALUOp from main control
//   funct      i  [5:0] instruction funct field
//   a, b       i  [WIDTH-1:0] operands
//   result     o  [WIDTH-1:0] registered ALU result
//   zero       o  registered, 1 when result == 0
//   alu_ctl    o  [2:0] registered decoded control code
//   out_valid  o  registered copy of in_valid
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [2:0]       alu_ctl,
  output logic             out_valid
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_NOR = 3'b100;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  logic [2:0]       ctl_d, ctl_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             valid_q;
  logic [WIDTH-1:0] diff;

  always_comb begin
    ctl_d = CTL_ADD;
    case (alu_op)
      2'b00: ctl_d = CTL_ADD;
      2'b01: ctl_d = CTL_SUB;
      default: begin
        case (funct)
          6'b100000: ctl_d = CTL_ADD;
          6'b100010: ctl_d = CTL_SUB;
          6'b100100: ctl_d = CTL_AND;
          6'b100101: ctl_d = CTL_OR;
          6'b101010: ctl_d = CTL_SLT;
`ifdef ALU_NOR_EN
          6'b100111: ctl_d = CTL_NOR;
`endif
          default:   ctl_d = CTL_ADD;
        endcase
      end
    endcase
  end

  // Shared subtractor for SUB and SLT. SLT takes the raw sign of the
  // difference with no overflow correction.
  assign diff = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    result_d = '0;
    case (ctl_d)
      CTL_AND: result_d = a & b;
      CTL_OR:  result_d = a | b;
      CTL_ADD: result_d = a + b;
      CTL_SUB: result_d = diff;
      CTL_SLT: result_d = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
`ifdef ALU_NOR_EN
      CTL_NOR: result_d = ~(a | b);
`endif
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  // Datapath registers update even when in_valid is low; only out_valid
  // qualifies them.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ctl_q    <= CTL_AND;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      ctl_q    <= ctl_d;
      valid_q  <= in_valid;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign alu_ctl   = ctl_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        zero;
  logic [2:0]  alu_ctl;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  // Expected register contents after the most recent edge.
  logic [15:0] exp_result;
  logic        exp_zero;
  logic [2:0]  exp_ctl;
  logic        exp_valid;

  alu_exec_unit #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .result    (result),
    .zero      (zero),
    .alu_ctl   (alu_ctl),
    .out_valid (out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_ctl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 3'd2;
    if (op == 2'd1) return 3'd6;
    if (f == 6'd32) return 3'd2;
    if (f == 6'd34) return 3'd6;
    if (f == 6'd36) return 3'd0;
    if (f == 6'd37) return 3'd1;
    if (f == 6'd42) return 3'd7;
`ifdef ALU_NOR_EN
    if (f == 6'd39) return 3'd4;
`endif
    return 3'd2;
  endfunction

  function automatic logic [15:0] ref_result(input logic [2:0] c, input logic [15:0] x, input logic [15:0] y);
    int ux, uy, d;
    ux = int'(x);
    uy = int'(y);
    d  = (ux - uy + 65536) % 65536;
    case (c)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return 16'((ux + uy) % 65536);
      3'd6: return 16'(d);
      3'd7: return (d >= 32768) ? 16'd1 : 16'd0;
`ifdef ALU_NOR_EN
      3'd4: return ~(x | y);
`endif
      default: return 16'd0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".result"}, 32'(result), 32'(exp_result));
    chk({tag, ".zero"},   32'(zero),   32'(exp_zero));
    chk({tag, ".ctl"},    32'(alu_ctl), 32'(exp_ctl));
    chk({tag, ".valid"},  32'(out_valid), 32'(exp_valid));
  endtask

  // Drive one cycle of inputs at the falling edge, confirm outputs do not
  // follow the inputs before the edge, then check the registered values.
  task automatic run_op(input string tag, input logic rst, input logic v,
                        input logic [1:0] op, input logic [5:0] f,
                        input logic [15:0] x, input logic [15:0] y);
    @(negedge clock);
    reset = rst; in_valid = v; alu_op = op; funct = f; a = x; b = y;
    #1;
    chk({tag, ".hold"}, 32'(result), 32'(exp_result));
    @(posedge clock);
    #1;
    if (rst) begin
      exp_result = 16'd0; exp_zero = 1'b1; exp_ctl = 3'd0; exp_valid = 1'b0;
    end else begin
      exp_ctl    = ref_ctl(op, f);
      exp_result = ref_result(exp_ctl, x, y);
      exp_zero   = (exp_result == 16'd0);
      exp_valid  = v;
    end
    check_outputs(tag);
  endtask

  logic [5:0] functs [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd63};

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_op = 2'd0; funct = 6'd0; a = 16'd0; b = 16'd0;
    exp_result = 16'd0; exp_zero = 1'b1; exp_ctl = 3'd0; exp_valid = 1'b0;

    run_op("rst1", 1'b1, 1'b0, 2'd0, 6'd0, 16'h0, 16'h0);
    run_op("rst2", 1'b1, 1'b0, 2'd0, 6'd0, 16'h0, 16'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_outputs("rel");

    run_op("idle",  1'b0, 1'b0, 2'b00, 6'd0,       16'h0000, 16'h0000);
    run_op("add",   1'b0, 1'b1, 2'b10, 6'b100000,  16'h0005, 16'h0007);
    run_op("slt1",  1'b0, 1'b1, 2'b10, 6'b101010,  16'h0005, 16'h0007);
    run_op("slt0",  1'b0, 1'b1, 2'b10, 6'b101010,  16'h0007, 16'h0005);
    run_op("sltov", 1'b0, 1'b1, 2'b10, 6'b101010,  16'h8000, 16'h0001);
    run_op("beq",   1'b0, 1'b1, 2'b01, 6'b000000,  16'h1234, 16'h1234);
    run_op("sub",   1'b0, 1'b1, 2'b10, 6'b100010,  16'h0005, 16'h0007);
    run_op("and",   1'b0, 1'b1, 2'b10, 6'b100100,  16'hF0F0, 16'hFF00);
    run_op("or",    1'b0, 1'b1, 2'b10, 6'b100101,  16'hF0F0, 16'hFF00);
    run_op("dflt",  1'b0, 1'b1, 2'b10, 6'b111111,  16'hF0F0, 16'hFF00);
    run_op("nor",   1'b0, 1'b1, 2'b10, 6'b100111,  16'hF0F0, 16'hFF00);
    run_op("lwsw",  1'b0, 1'b1, 2'b00, 6'b100100,  16'hFFFF, 16'h0001);
    run_op("addwr", 1'b0, 1'b1, 2'b11, 6'b100000,  16'hFFFF, 16'h0002);

    // Spot-check the hand-derived values from the plan against constants.
    run_op("k_add", 1'b0, 1'b1, 2'b10, 6'b100000, 16'h0005, 16'h0007);
    chk("k_add.const", 32'(result), 32'h000C);
    run_op("k_sub", 1'b0, 1'b1, 2'b10, 6'b100010, 16'h0005, 16'h0007);
    chk("k_sub.const", 32'(result), 32'hFFFE);
    run_op("k_nor", 1'b0, 1'b1, 2'b10, 6'b100111, 16'hF0F0, 16'hFF00);
`ifdef ALU_NOR_EN
    chk("k_nor.const", 32'(result), 32'h000F);
`else
    chk("k_nor.const", 32'(result), 32'hEFF0);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [15:0] rx, ry;
      rx = 16'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? rx : 16'($urandom);
      run_op("rnd", 1'b0, 1'($urandom), 2'($urandom),
             ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 7)],
             rx, ry);
    end

    // Reset together with in_valid mid-stream discards the operation.
    run_op("pre",   1'b0, 1'b1, 2'b10, 6'b100101, 16'h1234, 16'h0F0F);
    run_op("rstv",  1'b1, 1'b1, 2'b10, 6'b100000, 16'h1111, 16'h2222);
    chk("rstv.const_valid", 32'(out_valid), 32'd0);
    run_op("post",  1'b0, 1'b1, 2'b10, 6'b100000, 16'h1111, 16'h2222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage arithmetic block for the 16-bit pipelined MIPS-style CPU.
- Merges ALU control decode (2-bit ALUOp plus 6-bit funct field, giving a 3-bit ALU control code) with a 16-bit ALU.
- Registers result, zero flag and decoded control code. Output is valid one clock after the operands are presented.
- Consumers: EX/MEM pipeline register, branch decision (zero), load/store address path (add).

Parameters:
- WIDTH, 16, datapath width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op fields qualify this cycle.
- alu_op  input  2  ALUOp from main control.
- funct  input  6  instruction funct field (sign-extended immediate bits [5:0]).
- a  input  WIDTH  operand A (register rs).
- b  input  WIDTH  operand B (rt or immediate, already muxed).
- result  output  WIDTH  registered ALU result.
- zero  output  1  registered; 1 when result == 0.
- alu_ctl  output  3  registered decoded control code (debug/monitor).
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Decode (combinational), alu_op to ctl:
  - 00 gives 010 (ADD; lw/sw address).
  - 01 gives 110 (SUB; beq compare).
  - 1x decodes funct: 100000 ADD 010; 100010 SUB 110; 100100 AND 000; 100101 OR 001; 101010 SLT 111.
  - Any other funct under 1x gives ADD 010.
- Operations by ctl:
  - 000: a AND b.
  - 001: a OR b.
  - 010: a + b, carry discarded.
  - 110: a + ~b + 1.
  - 111: result = {0…0, MSB of (a − b)}. No overflow correction: a=0x8000, b=0x0001 gives 0x7FFF, so result 0.
  - Any other ctl code: result 0.
- zero is computed from the final selected result, including SLT and logic ops.
- Latency is exactly 1 clock. The rising edge after inputs are applied loads result, zero, alu_ctl and out_valid = in_valid.
- When in_valid=0, result/zero/alu_ctl are still updated from the current inputs. Only out_valid marks them meaningful.
- No stall or backpressure. A new operation is accepted every cycle.
- Reset, sampled at the rising edge, loads result=0, zero=1, alu_ctl=000, out_valid=0.
  - Reset has priority over simultaneous in_valid.
  - Reset asserted mid-stream discards the in-flight operation.
- Outputs hold their value between edges. No combinational path from inputs to outputs.

Optional Feature:
- Macro ALU_NOR_EN.
- When defined: under alu_op 1x, funct 100111 decodes to ctl 100, and ctl 100 produces ~(a | b).
- When not defined: funct 100111 falls to the default (ADD 010), and ctl 100 yields result 0.

Test Plan:
- reset=1 for 2 cycles, then released with in_valid=0 -> result=0x0000, zero=1, alu_ctl=000, out_valid=0.
- alu_op=10, funct=100000, a=0x0005, b=0x0007, in_valid=1 -> next edge: result=0x000C, zero=0, alu_ctl=010, out_valid=1.
- alu_op=10, funct=101010, a=5, b=7 -> result=0x0001. Then a=7, b=5 -> result=0x0000, zero=1. Then a=0x8000, b=0x0001 -> result=0x0000.
- alu_op=01, a=b=0x1234 -> result=0x0000, zero=1, alu_ctl=110. Then alu_op=10, funct=100010, a=5, b=7 -> result=0xFFFE.
- alu_op=10: funct 100100 with a=0xF0F0, b=0xFF00 -> 0xF000; funct 100101 -> 0xFFF0; funct 111111 -> ADD 0xEFF0. With ALU_NOR_EN, funct 100111 -> 0x000F; without it -> 0xEFF0.
- Back-to-back ops every cycle, then reset asserted in the same cycle as in_valid=1 -> next edge: out_valid=0, result=0, zero=1.
